// File: rtl/t_pulse_debouncer.sv
// Push-button conditioner: two-flop synchronizer, counter-based debounce FSM,
// one-cycle toggle pulse per accepted press, debounced level and press counter.
module t_pulse_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       t_out,
    output logic       btn_level,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 s1_q;
    logic                 s2_q;
    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 t_out_q;
    logic                 btn_level_q;
    logic [7:0]           press_count_q;
    logic [7:0]           press_count_d;

    // Incremented values for the window counter and the wrapping press counter
    always_comb begin
        cnt_d         = cnt_q + CNT_ONE;
        press_count_d = press_count_q + 8'd1;
    end

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM with registered pulse, level and press counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_ZERO;
            t_out_q       <= 1'b0;
            btn_level_q   <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            t_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s2_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_ZERO;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= PRESSED;
                        t_out_q       <= 1'b1;
                        btn_level_q   <= 1'b1;
                        press_count_q <= press_count_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                PRESSED: begin
                    if (!s2_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_ZERO;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high returns to PRESSED without a new pulse
                    if (s2_q) begin
                        state_q <= PRESSED;
                        cnt_q   <= CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= IDLE;
                        btn_level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= CNT_ZERO;
                    btn_level_q <= 1'b0;
                end
            endcase
        end
    end

    assign t_out       = t_out_q;
    assign btn_level   = btn_level_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_t_pulse_debouncer.sv
// Directed bench for t_pulse_debouncer with DEBOUNCE_CYCLES=4 and a T flip-flop
// driven by t_out.
module tb_t_pulse_debouncer;

    logic       clk;
    logic       rst_n;
    logic       btn_in;
    logic       t_out;
    logic       btn_level;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int dbl      = 0;
    logic t_prev = 1'b0;
    logic q_tff;

    t_pulse_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .t_out      (t_out),
        .btn_level  (btn_level),
        .press_count(press_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // T flip-flop stage fed by the pulse
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_tff <= 1'b0;
        else if (t_out) q_tff <= ~q_tff;
    end

    // Pulse monitor sampled on the falling edge
    always @(negedge clk) begin
        if (t_out) pulses++;
        if (t_out && t_prev) dbl++;
        t_prev = t_out;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        btn_in = 1'b0;
        rst_n  = 1'b0;
        #2;
        rst_n  = 1'b1;
        repeat (3) tick;
    endtask

    task automatic press_release(input int hold);
        btn_in = 1'b1;
        repeat (hold) tick;
        btn_in = 1'b0;
        repeat (hold) tick;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        btn_in = 1'b0;
        #2;
        n_checks++; if (t_out !== 1'b0) begin n_fail++; $display("FAIL reset_t_out got=%b exp=0", t_out); end
        n_checks++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL reset_level got=%b exp=0", btn_level); end
        n_checks++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", press_count); end
        #10;
        rst_n = 1'b1;
        repeat (5) tick;
        n_checks++; if (btn_level !== 1'b0 || t_out !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset level=%b t_out=%b exp=0,0", btn_level, t_out); end
    endtask

    task automatic test_clean_press;
        int p0;
        p0 = pulses;
        btn_in = 1'b1;
        repeat (6) tick;
        n_checks++; if (t_out !== 1'b0) begin n_fail++; $display("FAIL clean_early t_out=%b exp=0", t_out); end
        tick;
        n_checks++; if (t_out !== 1'b1) begin n_fail++; $display("FAIL clean_pulse t_out=%b exp=1", t_out); end
        n_checks++; if (btn_level !== 1'b1) begin n_fail++; $display("FAIL clean_level got=%b exp=1", btn_level); end
        n_checks++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL clean_count got=%0d exp=1", press_count); end
        tick;
        n_checks++; if (t_out !== 1'b0) begin n_fail++; $display("FAIL clean_pulse_end t_out=%b exp=0", t_out); end
        repeat (12) tick;
        btn_in = 1'b0;
        repeat (6) tick;
        n_checks++; if (btn_level !== 1'b1) begin n_fail++; $display("FAIL release_early level=%b exp=1", btn_level); end
        tick;
        n_checks++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL release_level level=%b exp=0", btn_level); end
        repeat (3) tick;
        n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL clean_pulse_count got=%0d exp=1", pulses - p0); end
    endtask

    task automatic test_bounce;
        int p0;
        do_reset();
        p0 = pulses;
        btn_in = 1'b1; tick;
        btn_in = 1'b0; tick;
        btn_in = 1'b1; tick;
        btn_in = 1'b0; tick;
        btn_in = 1'b1;
        repeat (6) tick;
        n_checks++; if (t_out !== 1'b0 || pulses != p0) begin n_fail++; $display("FAIL bounce_early t_out=%b pulses=%0d exp=0,0", t_out, pulses - p0); end
        tick;
        n_checks++; if (t_out !== 1'b1) begin n_fail++; $display("FAIL bounce_pulse t_out=%b exp=1", t_out); end
        repeat (10) tick;
        n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL bounce_pulse_count got=%0d exp=1", pulses - p0); end
        n_checks++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL bounce_count got=%0d exp=1", press_count); end
        btn_in = 1'b0;
        repeat (10) tick;
    endtask

    task automatic test_glitch;
        int p0;
        logic lvl_seen;
        do_reset();
        p0 = pulses;
        lvl_seen = 1'b0;
        // Three high cycles, then four (one short of acceptance)
        btn_in = 1'b1; repeat (3) tick;
        btn_in = 1'b0;
        for (int i = 0; i < 12; i++) begin tick; lvl_seen |= btn_level; end
        btn_in = 1'b1; repeat (4) tick;
        btn_in = 1'b0;
        for (int i = 0; i < 12; i++) begin tick; lvl_seen |= btn_level; end
        n_checks++; if (pulses - p0 !== 0) begin n_fail++; $display("FAIL glitch_pulses got=%0d exp=0", pulses - p0); end
        n_checks++; if (lvl_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_level got=%b exp=0", lvl_seen); end
        n_checks++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL glitch_count got=%0d exp=0", press_count); end
        // Five high cycles is the shortest accepted press
        btn_in = 1'b1; repeat (5) tick;
        btn_in = 1'b0; repeat (2) tick;
        n_checks++; if (press_count !== 8'd1 || btn_level !== 1'b1) begin n_fail++; $display("FAIL min_press count=%0d level=%b exp=1,1", press_count, btn_level); end
        repeat (10) tick;
    endtask

    task automatic test_release_bounce;
        int p0;
        logic lvl_low;
        do_reset();
        btn_in = 1'b1;
        repeat (10) tick;
        p0 = pulses;
        lvl_low = 1'b0;
        btn_in = 1'b0;
        for (int i = 0; i < 2; i++) begin tick; lvl_low |= ~btn_level; end
        btn_in = 1'b1;
        for (int i = 0; i < 3; i++) begin tick; lvl_low |= ~btn_level; end
        btn_in = 1'b0;
        for (int i = 0; i < 6; i++) begin tick; lvl_low |= ~btn_level; end
        n_checks++; if (lvl_low !== 1'b0) begin n_fail++; $display("FAIL rel_bounce_level dropped=%b exp=0", lvl_low); end
        tick;
        n_checks++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL rel_bounce_final level=%b exp=0", btn_level); end
        repeat (3) tick;
        n_checks++; if (pulses - p0 !== 0) begin n_fail++; $display("FAIL rel_bounce_pulses got=%0d exp=0", pulses - p0); end
        n_checks++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL rel_bounce_count got=%0d exp=1", press_count); end
    endtask

    task automatic test_wrap;
        int p0;
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b1;
            repeat (10) tick;
            if (i == 254) begin
                n_checks++; if (press_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got=%0d exp=255", press_count); end
            end
            btn_in = 1'b0;
            repeat (10) tick;
        end
        n_checks++; if (pulses - p0 !== 256) begin n_fail++; $display("FAIL wrap_pulses got=%0d exp=256", pulses - p0); end
        n_checks++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL wrap_count got=%0d exp=0", press_count); end
        n_checks++; if (dbl !== 0) begin n_fail++; $display("FAIL double_pulse got=%0d exp=0", dbl); end
    endtask

    task automatic test_reset_mid;
        int p0;
        do_reset();
        press_release(10);
        btn_in = 1'b1;
        repeat (4) tick;
        rst_n = 1'b0;
        #1;
        n_checks++; if (press_count !== 8'd0 || btn_level !== 1'b0 || t_out !== 1'b0) begin n_fail++; $display("FAIL reset_mid count=%0d level=%b t_out=%b exp=0,0,0", press_count, btn_level, t_out); end
        #2;
        rst_n = 1'b1;
        repeat (6) tick;
        n_checks++; if (t_out !== 1'b0) begin n_fail++; $display("FAIL held_early t_out=%b exp=0", t_out); end
        tick;
        n_checks++; if (t_out !== 1'b1 || press_count !== 8'd1) begin n_fail++; $display("FAIL held_pulse t_out=%b count=%0d exp=1,1", t_out, press_count); end
        // Reset in the pulse cycle kills the pulse at once
        p0 = pulses;
        rst_n = 1'b0;
        #1;
        n_checks++; if (t_out !== 1'b0) begin n_fail++; $display("FAIL reset_pulse t_out=%b exp=0", t_out); end
        #2;
        rst_n = 1'b1;
        repeat (2) tick;
        n_checks++; if (pulses - p0 !== 0 || q_tff !== 1'b0) begin n_fail++; $display("FAIL reset_pulse_effect pulses=%0d q=%b exp=0,0", pulses - p0, q_tff); end
        // Button still held: one press, then two more, toggles q three times
        repeat (10) tick;
        n_checks++; if (q_tff !== 1'b1) begin n_fail++; $display("FAIL tff_first q=%b exp=1", q_tff); end
        btn_in = 1'b0;
        repeat (10) tick;
        press_release(10);
        n_checks++; if (q_tff !== 1'b0) begin n_fail++; $display("FAIL tff_second q=%b exp=0", q_tff); end
        press_release(10);
        n_checks++; if (q_tff !== 1'b1 || press_count !== 8'd3) begin n_fail++; $display("FAIL tff_third q=%b count=%0d exp=1,3", q_tff, press_count); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_bounce();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
